pipe_ctrl_hazard: RTL and testbench

//  Receiving end of the decoder's control bits (mem_read/mem_write/reg_write/jump/branch).

---
 rtl/pipe_ctrl_hazard_pkg.sv | 27 ++
 rtl/pipe_ctrl_hazard_if.sv | 52 +++++
 rtl/pipe_ctrl_hazard_detect.sv | 109 ++++++++++
 rtl/pipe_ctrl_hazard.sv | 129 ++++++++++++
 tb/tb_pipe_ctrl_hazard.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_hazard_pkg.sv
// Shared types for the ID->WB control pipeline: control-bit struct, NOP
// encoding, forwarding-select codes and a small helper.
// No logic of its own; imported by the interface, the hazard detector and the top.
package pipe_ctrl_hazard_pkg;

  // Field order matches the decoder's {mem_read,mem_write,reg_write,jump,branch}.
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic jump;
    logic branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from MEM/WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from EX/MEM result

  // A stage produces a register value only if it holds a real instruction
  // that writes the register file.
  function automatic logic writes_reg(input logic valid, input logic reg_write);
    return valid & reg_write;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_if.sv
// Bundle between the ID-stage decoder/datapath and the control pipeline.
// master: drives ID fields and ex_redirect, observes stage contents, stall/flush and fwd.
// slave : the pipe_ctrl_hazard block itself.
interface pipe_ctrl_hazard_if #(
  parameter int REG_AW = 5
);
  import pipe_ctrl_hazard_pkg::*;

  // ID side
  logic              id_valid;
  ctrl_t             id_ctrl;
  logic [REG_AW-1:0] id_rd;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              ex_redirect;

  // front-end control
  logic              stall_if_id;
  logic              flush_if_id;

  // stage contents
  logic              ex_valid;
  ctrl_t             ex_ctrl;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_valid;
  ctrl_t             mem_ctrl;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_valid;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;

  // EX operand source selects
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  modport master (
    output id_valid, id_ctrl, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_redirect,
    input  stall_if_id, flush_if_id,
    input  ex_valid, ex_ctrl, ex_rd, mem_valid, mem_ctrl, mem_rd,
    input  wb_valid, wb_reg_write, wb_rd, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_ctrl, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_redirect,
    output stall_if_id, flush_if_id,
    output ex_valid, ex_ctrl, ex_rd, mem_valid, mem_ctrl, mem_rd,
    output wb_valid, wb_reg_write, wb_rd, fwd_a, fwd_b
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Purpose: RAW/load-use hazard detection and EX operand forwarding selects.
// Latency: purely combinational from stage registers and ID fields.
// Backpressure: raises stall when the ID instruction cannot enter EX yet.
// Macro FORWARDING_EN: defined -> forward from EX/MEM / MEM/WB, stall only on
// load-use; undefined -> fwd tied to FWD_REG, stall on any ID/EX or EX/MEM match.
// Ports: ID consumer fields, ID/EX / EX/MEM / MEM/WB producer fields,
// ID/EX consumer fields (for forwarding); outputs stall, fwd_a, fwd_b.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic              ex_use_rs1,
  input  logic              ex_use_rs2,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic raw_hit(input logic              prod_wr,
                                   input logic [REG_AW-1:0] prod_rd,
                                   input logic              cons_en,
                                   input logic [REG_AW-1:0] cons_rs);
    return prod_wr && (prod_rd != '0) && (prod_rd == cons_rs) && cons_en;
  endfunction

  logic ex_wr;
  logic mem_wr;
  logic id_rs1_en;
  logic id_rs2_en;
  logic id_hit_ex;

  assign ex_wr     = writes_reg(ex_valid, ex_reg_write);
  assign mem_wr    = writes_reg(mem_valid, mem_reg_write);
  assign id_rs1_en = id_valid & id_use_rs1;
  assign id_rs2_en = id_valid & id_use_rs2;
  assign id_hit_ex = raw_hit(ex_wr, ex_rd, id_rs1_en, id_rs1) |
                     raw_hit(ex_wr, ex_rd, id_rs2_en, id_rs2);

`ifdef FORWARDING_EN
  logic wb_wr;
  logic mem_fwd_ok;
  logic ex_rs1_en;
  logic ex_rs2_en;

  assign wb_wr      = writes_reg(wb_valid, wb_reg_write);
  // Load data is not available until MEM/WB, so EX/MEM cannot supply it.
  assign mem_fwd_ok = mem_wr & ~mem_mem_read;
  assign ex_rs1_en  = ex_valid & ex_use_rs1;
  assign ex_rs2_en  = ex_valid & ex_use_rs2;

  // Only a load directly ahead in EX cannot be covered by forwarding.
  assign stall = id_hit_ex & ex_mem_read;

  // EX/MEM holds the younger result, so it takes priority over MEM/WB.
  always_comb begin
    fwd_a = FWD_REG;
    if (raw_hit(mem_fwd_ok, mem_rd, ex_rs1_en, ex_rs1)) begin
      fwd_a = FWD_MEM;
    end else if (raw_hit(wb_wr, wb_rd, ex_rs1_en, ex_rs1)) begin
      fwd_a = FWD_WB;
    end
  end

  always_comb begin
    fwd_b = FWD_REG;
    if (raw_hit(mem_fwd_ok, mem_rd, ex_rs2_en, ex_rs2)) begin
      fwd_b = FWD_MEM;
    end else if (raw_hit(wb_wr, wb_rd, ex_rs2_en, ex_rs2)) begin
      fwd_b = FWD_WB;
    end
  end
`else
  logic id_hit_mem;
  logic unused_fwd_inputs;

  assign id_hit_mem = raw_hit(mem_wr, mem_rd, id_rs1_en, id_rs1) |
                      raw_hit(mem_wr, mem_rd, id_rs2_en, id_rs2);

  // Without bypass paths the consumer waits until the producer reaches WB;
  // the write-first register file then returns the new value.
  assign stall = id_hit_ex | id_hit_mem;
  assign fwd_a = FWD_REG;
  assign fwd_b = FWD_REG;

  assign unused_fwd_inputs = ^{ex_mem_read, mem_mem_read, ex_rs1, ex_rs2,
                               ex_use_rs1, ex_use_rs2, wb_valid, wb_reg_write, wb_rd};
`endif

endmodule

// File: rtl/pipe_ctrl_hazard.sv
// Purpose: carries decoder control bits + rd/rs through ID/EX, EX/MEM, MEM/WB;
//          injects bubbles on hazards and EX redirects.
// Latency: 1 cycle per stage; stall/flush/fwd are combinational from registers and ID inputs.
// Backpressure: stall_if_id holds IF/ID; downstream of ID never stalls.
// Macro FORWARDING_EN selects bypass forwarding (see pipe_ctrl_hazard_detect).
// Ports: clk, rst (sync, active-high); bus (slave modport of pipe_ctrl_hazard_if).
module pipe_ctrl_hazard
  import pipe_ctrl_hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  pipe_ctrl_hazard_if.slave bus
);

  // ID/EX
  logic              ex_valid_q;
  ctrl_t             ex_ctrl_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic [REG_AW-1:0] ex_rs1_q;
  logic [REG_AW-1:0] ex_rs2_q;
  logic              ex_use_rs1_q;
  logic              ex_use_rs2_q;
  // EX/MEM
  logic              mem_valid_q;
  ctrl_t             mem_ctrl_q;
  logic [REG_AW-1:0] mem_rd_q;
  // MEM/WB
  logic              wb_valid_q;
  logic              wb_reg_write_q;
  logic [REG_AW-1:0] wb_rd_q;

  logic       stall_raw;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       bubble;

  pipe_ctrl_hazard_detect #(
    .REG_AW (REG_AW)
  ) u_detect (
    .id_valid      (bus.id_valid),
    .id_rs1        (bus.id_rs1),
    .id_rs2        (bus.id_rs2),
    .id_use_rs1    (bus.id_use_rs1),
    .id_use_rs2    (bus.id_use_rs2),
    .ex_valid      (ex_valid_q),
    .ex_reg_write  (ex_ctrl_q.reg_write),
    .ex_mem_read   (ex_ctrl_q.mem_read),
    .ex_rd         (ex_rd_q),
    .ex_rs1        (ex_rs1_q),
    .ex_rs2        (ex_rs2_q),
    .ex_use_rs1    (ex_use_rs1_q),
    .ex_use_rs2    (ex_use_rs2_q),
    .mem_valid     (mem_valid_q),
    .mem_reg_write (mem_ctrl_q.reg_write),
    .mem_mem_read  (mem_ctrl_q.mem_read),
    .mem_rd        (mem_rd_q),
    .wb_valid      (wb_valid_q),
    .wb_reg_write  (wb_reg_write_q),
    .wb_rd         (wb_rd_q),
    .stall         (stall_raw),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  // The ID instruction enters EX only if it is real, has no unresolved hazard
  // and is not on the wrong path of a redirect resolved in EX.
  assign bubble = ~bus.id_valid | stall_raw | bus.ex_redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_ctrl_q      <= CTRL_NOP;
      ex_rd_q        <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_use_rs1_q   <= 1'b0;
      ex_use_rs2_q   <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_ctrl_q     <= CTRL_NOP;
      mem_rd_q       <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
    end else begin
      if (bubble) begin
        ex_valid_q   <= 1'b0;
        ex_ctrl_q    <= CTRL_NOP;
        ex_rd_q      <= '0;
        ex_rs1_q     <= '0;
        ex_rs2_q     <= '0;
        ex_use_rs1_q <= 1'b0;
        ex_use_rs2_q <= 1'b0;
      end else begin
        ex_valid_q   <= 1'b1;
        ex_ctrl_q    <= bus.id_ctrl;
        ex_rd_q      <= bus.id_rd;
        ex_rs1_q     <= bus.id_rs1;
        ex_rs2_q     <= bus.id_rs2;
        ex_use_rs1_q <= bus.id_use_rs1;
        ex_use_rs2_q <= bus.id_use_rs2;
      end
      mem_valid_q    <= ex_valid_q;
      mem_ctrl_q     <= ex_ctrl_q;
      mem_rd_q       <= ex_rd_q;
      wb_valid_q     <= mem_valid_q;
      wb_reg_write_q <= mem_ctrl_q.reg_write;
      wb_rd_q        <= mem_rd_q;
    end
  end

  // Redirect wins: the stalled instruction is on the wrong path anyway.
  assign bus.stall_if_id  = stall_raw & ~bus.ex_redirect & ~rst;
  assign bus.flush_if_id  = bus.ex_redirect & ~rst;
  assign bus.fwd_a        = fwd_a;
  assign bus.fwd_b        = fwd_b;

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_ctrl      = ex_ctrl_q;
  assign bus.ex_rd        = ex_rd_q;
  assign bus.mem_valid    = mem_valid_q;
  assign bus.mem_ctrl     = mem_ctrl_q;
  assign bus.mem_rd       = mem_rd_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_reg_write = wb_reg_write_q;
  assign bus.wb_rd        = wb_rd_q;

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Bench for pipe_ctrl_hazard: cycle-scripted ID stimulus with per-cycle
// expected stall/flush/fwd/ID-EX contents, plus a retirement scoreboard that
// matches every wb_valid against instructions the script expects to be accepted.
module tb_pipe_ctrl_hazard;
  import pipe_ctrl_hazard_pkg::*;

  localparam int AW = 5;
`ifdef FORWARDING_EN
  localparam bit FWD   = 1'b1;
  localparam int N_LU  = 1;   // stall cycles for load-use
  localparam int N_RAW = 0;   // stall cycles for ALU RAW
`else
  localparam bit FWD   = 1'b0;
  localparam int N_LU  = 2;
  localparam int N_RAW = 2;
`endif
  localparam logic [1:0] F0 = 2'b00;
  localparam logic [1:0] FM = FWD ? 2'b10 : 2'b00;
  localparam logic [1:0] FW = FWD ? 2'b01 : 2'b00;

  localparam logic [4:0] C_LW  = 5'b10100;
  localparam logic [4:0] C_ALU = 5'b00100;
  localparam logic [4:0] C_SW  = 5'b01000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_hazard_if #(.REG_AW(AW)) bus();

  pipe_ctrl_hazard #(.REG_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic          rw;
  } ret_t;

  ret_t          exp_q[$];
  ret_t          mon_e;
  logic          exp_ex_v    = 1'b0;
  logic [4:0]    exp_ex_ctrl = 5'b0;
  logic [AW-1:0] exp_ex_rd   = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive ID, check mid-cycle, record acceptance, advance.
  task automatic cyc(input logic v, input logic [4:0] c, input logic [AW-1:0] rd,
                     input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                     input logic u1, input logic u2, input logic redir,
                     input logic est, input logic [1:0] efa, input logic [1:0] efb,
                     input string tag);
    logic acc;
    bus.id_valid    = v;
    bus.id_ctrl     = c;
    bus.id_rd       = rd;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_use_rs1  = u1;
    bus.id_use_rs2  = u2;
    bus.ex_redirect = redir;
    @(negedge clk);
    chk({tag, ".stall"},    32'(bus.stall_if_id), 32'(est));
    chk({tag, ".flush"},    32'(bus.flush_if_id), 32'(redir));
    chk({tag, ".ex_valid"}, 32'(bus.ex_valid),    32'(exp_ex_v));
    chk({tag, ".ex_ctrl"},  32'(bus.ex_ctrl),     32'(exp_ex_ctrl));
    if (exp_ex_v) chk({tag, ".ex_rd"}, 32'(bus.ex_rd), 32'(exp_ex_rd));
    chk({tag, ".fwd_a"},    32'(bus.fwd_a),       32'(efa));
    chk({tag, ".fwd_b"},    32'(bus.fwd_b),       32'(efb));
    acc = v & ~est & ~redir;
    if (acc) exp_q.push_back(ret_t'{rd, c[2]});
    exp_ex_v    = acc;
    exp_ex_ctrl = acc ? c : 5'b0;
    exp_ex_rd   = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [1:0] efa, input logic [1:0] efb, input string tag);
    cyc(1'b0, 5'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, efa, efb, tag);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) idle(F0, F0, "drain");
  endtask

  // Retirement scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'(bus.wb_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_rd", 32'(bus.wb_rd), 32'(mon_e.rd));
        chk("wb_reg_write", 32'(bus.wb_reg_write), 32'(mon_e.rw));
      end
    end
  end

  initial begin
    // 1: reset dominates a valid ID instruction
    bus.id_valid    = 1'b1;
    bus.id_ctrl     = C_ALU;
    bus.id_rd       = 5'd3;
    bus.id_rs1      = 5'd3;
    bus.id_rs2      = 5'd3;
    bus.id_use_rs1  = 1'b1;
    bus.id_use_rs2  = 1'b1;
    bus.ex_redirect = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ex_valid",  32'(bus.ex_valid),     32'd0);
    chk("rst.ex_ctrl",   32'(bus.ex_ctrl),      32'd0);
    chk("rst.ex_rd",     32'(bus.ex_rd),        32'd0);
    chk("rst.mem_valid", 32'(bus.mem_valid),    32'd0);
    chk("rst.mem_ctrl",  32'(bus.mem_ctrl),     32'd0);
    chk("rst.mem_rd",    32'(bus.mem_rd),       32'd0);
    chk("rst.wb_valid",  32'(bus.wb_valid),     32'd0);
    chk("rst.wb_rw",     32'(bus.wb_reg_write), 32'd0);
    chk("rst.wb_rd",     32'(bus.wb_rd),        32'd0);
    chk("rst.stall",     32'(bus.stall_if_id),  32'd0);
    chk("rst.flush",     32'(bus.flush_if_id),  32'd0);
    chk("rst.fwd_a",     32'(bus.fwd_a),        32'd0);
    chk("rst.fwd_b",     32'(bus.fwd_b),        32'd0);
    bus.id_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 2: lw x5 ; add x6,x5,x1 -> load-use
    cyc(1'b1, C_LW, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, F0, F0, "t2_lw");
    for (int k = 0; k < N_LU; k++)
      cyc(1'b1, C_ALU, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, F0, F0, "t2_stall");
    cyc(1'b1, C_ALU, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, F0, F0, "t2_add");
    idle(FW, F0, "t2_fwd");
    drain();

    // 2b: lw x25 ; sw x25,0(x1) -> load-use through rs2
    cyc(1'b1, C_LW, 5'd25, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, F0, F0, "t2b_lw");
    for (int k = 0; k < N_LU; k++)
      cyc(1'b1, C_SW, 5'd0, 5'd1, 5'd25, 1'b1, 1'b1, 1'b0, 1'b1, F0, F0, "t2b_stall");
    cyc(1'b1, C_SW, 5'd0, 5'd1, 5'd25, 1'b1, 1'b1, 1'b0, 1'b0, F0, F0, "t2b_sw");
    idle(F0, FW, "t2b_fwd");
    drain();

    // 3: addi x7 ; sub x8,x7,x7
    cyc(1'b1, C_ALU, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, F0, F0, "t3_addi");
    for (int k = 0; k < N_RAW; k++)
      cyc(1'b1, C_ALU, 5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, F0, F0, "t3_stall");
    cyc(1'b1, C_ALU, 5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, F0, F0, "t3_sub");
    idle(FM, FM, "t3_fwd");
    drain();

    // 3b: addi x10 ; addi x10 ; add x11,x10,x10 -> EX/MEM beats MEM/WB
    cyc(1'b1, C_ALU, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, F0, F0, "t3b_i1");
    cyc(1'b1, C_ALU, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, F0, F0, "t3b_i2");
    for (int k = 0; k < N_RAW; k++)
      cyc(1'b1, C_ALU, 5'd11, 5'd10, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, F0, F0, "t3b_stall");
    cyc(1'b1, C_ALU, 5'd11, 5'd10, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, F0, F0, "t3b_add");
    idle(FM, FM, "t3b_fwd");
    drain();

    // 3c: addi x12 ; addi x13 ; add x14,x13,x12 -> a from MEM, b from WB
    cyc(1'b1, C_ALU, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, F0, F0, "t3c_i1");
    cyc(1'b1, C_ALU, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, F0, F0, "t3c_i2");
    for (int k = 0; k < N_RAW; k++)
      cyc(1'b1, C_ALU, 5'd14, 5'd13, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, F0, F0, "t3c_stall");
    cyc(1'b1, C_ALU, 5'd14, 5'd13, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, F0, F0, "t3c_add");
    idle(FM, FW, "t3c_fwd");
    drain();

    // 4: addi x0,x0,1 ; add x9,x0,x0 -> x0 never hazards
    cyc(1'b1, C_ALU, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, F0, F0, "t4_addi");
    cyc(1'b1, C_ALU, 5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, F0, F0, "t4_add");
    idle(F0, F0, "t4_fwd");
    drain();

    // 4b: matching index but operand not read -> no hazard
    cyc(1'b1, C_ALU, 5'd15, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, F0, F0, "t4b_i1");
    cyc(1'b1, C_ALU, 5'd16, 5'd15, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, F0, F0, "t4b_i2");
    idle(F0, F0, "t4b_fwd");
    drain();

    // 5: redirect in the same cycle as a load-use match
    cyc(1'b1, C_LW, 5'd20, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, F0, F0, "t5_lw");
    cyc(1'b1, C_ALU, 5'd21, 5'd20, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, F0, F0, "t5_redir");
    idle(F0, F0, "t5_bubble");
    drain();

    // 6: reset with sw in EX/MEM and add in MEM/WB
    cyc(1'b1, C_ALU, 5'd22, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, F0, F0, "t6_add");
    cyc(1'b1, C_SW, 5'd0, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, F0, F0, "t6_sw");
    idle(F0, F0, "t6_adv");
    rst = 1'b1;
    bus.id_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6.ex_valid",  32'(bus.ex_valid),     32'd0);
    chk("t6.mem_valid", 32'(bus.mem_valid),    32'd0);
    chk("t6.mem_ctrl",  32'(bus.mem_ctrl),     32'd0);
    chk("t6.wb_valid",  32'(bus.wb_valid),     32'd0);
    chk("t6.wb_rw",     32'(bus.wb_reg_write), 32'd0);
    chk("t6.killed",    32'(exp_q.size()),     32'd2);
    exp_q.delete();
    exp_ex_v    = 1'b0;
    exp_ex_ctrl = 5'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    drain();

    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
